// File: rtl/wb_bus_arbiter_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the shared slave.
`timescale 1ns/1ps

interface wb_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SEL_W = DATA_W / 8;

    // Master 0: instruction fetch
    logic              m0_cyc_i;
    logic              m0_stb_i;
    logic              m0_we_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_dat_i;
    logic [SEL_W-1:0]  m0_sel_i;
    logic [DATA_W-1:0] m0_dat_o;
    logic              m0_ack_o;
    logic              m0_err_o;

    // Master 1: MEM-stage load/store unit
    logic              m1_cyc_i;
    logic              m1_stb_i;
    logic              m1_we_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_dat_i;
    logic [SEL_W-1:0]  m1_sel_i;
    logic [DATA_W-1:0] m1_dat_o;
    logic              m1_ack_o;
    logic              m1_err_o;

    // Shared slave
    logic              wbs_cyc_o;
    logic              wbs_stb_o;
    logic              wbs_we_o;
    logic [ADDR_W-1:0] wbs_addr_o;
    logic [DATA_W-1:0] wbs_dat_o;
    logic [SEL_W-1:0]  wbs_sel_o;
    logic [DATA_W-1:0] wbs_dat_i;
    logic              wbs_ack_i;
    logic              wbs_err_i;

    // View taken by the arbiter: it is the slave of both masters and drives the shared slave
    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_dat_i, m0_sel_i,
        output m0_dat_o, m0_ack_o, m0_err_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_dat_i, m1_sel_i,
        output m1_dat_o, m1_ack_o, m1_err_o,
        output wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_addr_o, wbs_dat_o, wbs_sel_o,
        input  wbs_dat_i, wbs_ack_i, wbs_err_i
    );

    // View of the surroundings: the two masters plus the memory slave
    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_addr_i, m0_dat_i, m0_sel_i,
        input  m0_dat_o, m0_ack_o, m0_err_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_dat_i, m1_sel_i,
        input  m1_dat_o, m1_ack_o, m1_err_o,
        input  wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_addr_o, wbs_dat_o, wbs_sel_o,
        output wbs_dat_i, wbs_ack_i, wbs_err_i
    );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone arbiter: round-robin on ties, grant held for the
// whole cyc, responses routed to the owner only, watchdog turns a hung slave into err.
`timescale 1ns/1ps

module wb_bus_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    wb_bus_arbiter_if.slave    bus,
    output logic [1:0]         gnt_o
);
    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;

    logic              owned;
    logic              own_cyc;
    logic              own_stb;
    logic              own_we;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_dat;
    logic [SEL_W-1:0]  own_sel;
    logic              slv_resp;
    logic              wd_fire;

    // Select the current owner's request signals; nothing is forwarded while idle
    always_comb begin
        owned    = 1'b0;
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_addr = '0;
        own_dat  = '0;
        own_sel  = '0;
        unique case (state_q)
            OWN0: begin
                owned    = 1'b1;
                own_cyc  = bus.m0_cyc_i;
                own_stb  = bus.m0_stb_i;
                own_we   = bus.m0_we_i;
                own_addr = bus.m0_addr_i;
                own_dat  = bus.m0_dat_i;
                own_sel  = bus.m0_sel_i;
            end
            OWN1: begin
                owned    = 1'b1;
                own_cyc  = bus.m1_cyc_i;
                own_stb  = bus.m1_stb_i;
                own_we   = bus.m1_we_i;
                own_addr = bus.m1_addr_i;
                own_dat  = bus.m1_dat_i;
                own_sel  = bus.m1_sel_i;
            end
            default: ;
        endcase
    end

    // A real slave answer in the expiry cycle takes precedence over the forced error
    assign slv_resp = bus.wbs_ack_i | bus.wbs_err_i;
    assign wd_fire  = owned & own_stb & ~slv_resp & (wd_cnt_q == WD_W'(TIMEOUT - 1));

    // Slave-side request: owner's signals, cyc/stb dropped in the watchdog cycle
    assign bus.wbs_cyc_o  = own_cyc & ~wd_fire;
    assign bus.wbs_stb_o  = own_stb & ~wd_fire;
    assign bus.wbs_we_o   = own_we;
    assign bus.wbs_addr_o = own_addr;
    assign bus.wbs_dat_o  = own_dat;
    assign bus.wbs_sel_o  = own_sel;

    // Response routing: only the owner sees ack/err/data, the other master sees zeros
    assign bus.m0_ack_o = (state_q == OWN0) & bus.wbs_ack_i;
    assign bus.m0_err_o = (state_q == OWN0) & (bus.wbs_err_i | wd_fire);
    assign bus.m0_dat_o = (state_q == OWN0) ? bus.wbs_dat_i : '0;
    assign bus.m1_ack_o = (state_q == OWN1) & bus.wbs_ack_i;
    assign bus.m1_err_o = (state_q == OWN1) & (bus.wbs_err_i | wd_fire);
    assign bus.m1_dat_o = (state_q == OWN1) ? bus.wbs_dat_i : '0;

    assign gnt_o = {state_q == OWN1, state_q == OWN0};

    // Next-state, round-robin pointer and watchdog counter
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        wd_cnt_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    state_d = last_gnt_q ? OWN0 : OWN1;
                end else if (bus.m0_cyc_i) begin
                    state_d = OWN0;
                end else if (bus.m1_cyc_i) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!own_cyc || wd_fire) begin
                    state_d    = IDLE;
                    last_gnt_d = (state_q == OWN1);
                end else if (own_stb && !slv_resp) begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset releases the bus asynchronously
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b0;
            wd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

    // Structural invariants of the grant and the slave cycle
    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_i) $onehot0(gnt_o));
    a_cyc_owned:  assert property (@(posedge clk_i) disable iff (!rst_i)
                                   bus.wbs_cyc_o |-> (gnt_o != 2'b00));

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level ownership model.
`timescale 1ns/1ps

module tb_wb_bus_arbiter;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SEL_W   = DATA_W / 8;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned OUT_W   = 3 + ADDR_W + DATA_W + SEL_W + 2 * (2 + DATA_W) + 2;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [1:0] gnt_o;
    int         tests = 0;
    int         fails = 0;

    wb_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wb_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus),
        .gnt_o (gnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Every DUT output packed into one vector
    function automatic logic [OUT_W-1:0] all_outs();
        return {bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_we_o, bus.wbs_addr_o, bus.wbs_dat_o,
                bus.wbs_sel_o, bus.m0_ack_o, bus.m0_err_o, bus.m0_dat_o,
                bus.m1_ack_o, bus.m1_err_o, bus.m1_dat_o, gnt_o};
    endfunction

    task automatic idle_inputs();
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0;
        bus.m0_addr_i = '0; bus.m0_dat_i = '0; bus.m0_sel_i = '0;
        bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0;
        bus.m1_addr_i = '0; bus.m1_dat_i = '0; bus.m1_sel_i = '0;
        bus.wbs_dat_i = '0; bus.wbs_ack_i = 0; bus.wbs_err_i = 0;
    endtask

    // Drive point just after the rising edge
    task automatic drive_pt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [ADDR_W-1:0] a;
        idle_inputs();
        rst_i = 0;
        #1;
        tests++;
        if (all_outs() !== '0) begin
            fails++; $display("FAIL reset_outs: got %h expected 0", all_outs());
        end
        drive_pt();
        rst_i = 1;
        a = $urandom;
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = 1; bus.m1_addr_i = a;
        @(negedge clk_i);
        tests++;
        if (gnt_o !== 2'b00) begin
            fails++; $display("FAIL reset_arb_latency: gnt got %b expected 00", gnt_o);
        end
        drive_pt();
        @(negedge clk_i);
        tests++;
        if ({gnt_o, bus.wbs_cyc_o, bus.wbs_addr_o} !== {2'b10, 1'b1, a}) begin
            fails++; $display("FAIL reset_own1: got gnt=%b cyc=%b addr=%h expected 10 1 %h",
                              gnt_o, bus.wbs_cyc_o, bus.wbs_addr_o, a);
        end
        #1 rst_i = 0;
        #1;
        tests++;
        if ({gnt_o, bus.wbs_cyc_o, bus.wbs_stb_o} !== 4'b0000) begin
            fails++; $display("FAIL reset_midxfer: got gnt=%b cyc=%b stb=%b expected 00 0 0",
                              gnt_o, bus.wbs_cyc_o, bus.wbs_stb_o);
        end
        idle_inputs();
        drive_pt();
        rst_i = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            tests++;
            if (all_outs() !== '0) begin
                fails++; $display("FAIL reset_idle_%0d: got %h expected 0", i, all_outs());
            end
            drive_pt();
        end
    endtask

    task automatic test_single_read();
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_we_i = 0;
        bus.m0_addr_i = 32'h0000_0100; bus.m0_sel_i = 4'hF;
        @(negedge clk_i);
        tests++;
        if (bus.wbs_cyc_o !== 1'b0) begin
            fails++; $display("FAIL read_latency: wbs_cyc got %b expected 0", bus.wbs_cyc_o);
        end
        drive_pt();
        @(negedge clk_i);
        tests++;
        if ({bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_addr_o, gnt_o, bus.m0_ack_o} !==
            {1'b1, 1'b1, 32'h0000_0100, 2'b01, 1'b0}) begin
            fails++; $display("FAIL read_grant: cyc=%b stb=%b addr=%h gnt=%b ack=%b expected 1 1 00000100 01 0",
                              bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbs_addr_o, gnt_o, bus.m0_ack_o);
        end
        drive_pt();
        bus.wbs_ack_i = 1; bus.wbs_dat_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        tests++;
        if ({bus.m0_ack_o, bus.m0_dat_o, bus.m1_ack_o, bus.m1_dat_o} !==
            {1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0}) begin
            fails++; $display("FAIL read_data: m0 ack=%b dat=%h m1 ack=%b dat=%h expected 1 deadbeef 0 0",
                              bus.m0_ack_o, bus.m0_dat_o, bus.m1_ack_o, bus.m1_dat_o);
        end
        drive_pt();
        idle_inputs();
        @(negedge clk_i);
        tests++;
        if ({bus.wbs_cyc_o, gnt_o} !== {1'b0, 2'b01}) begin
            fails++; $display("FAIL read_release: cyc=%b gnt=%b expected 0 01", bus.wbs_cyc_o, gnt_o);
        end
        drive_pt();
        @(negedge clk_i);
        drive_pt();
    endtask

    task automatic test_contention();
        rst_i = 0;
        drive_pt();
        rst_i = 1;
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
        // expected grant per cycle: tie, m1, m1 drops, gap, m0, m0 drops, tie again, m1
        begin
            logic [1:0] exp_g [8] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
            for (int c = 0; c < 8; c++) begin
                if (c == 2) begin bus.m1_cyc_i = 0; bus.m1_stb_i = 0; end
                if (c == 5) begin bus.m0_cyc_i = 0; bus.m0_stb_i = 0; end
                if (c == 6) begin
                    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
                end
                @(negedge clk_i);
                tests++;
                if (gnt_o !== exp_g[c]) begin
                    fails++; $display("FAIL contention_c%0d: gnt got %b expected %b", c, gnt_o, exp_g[c]);
                end
                drive_pt();
            end
        end
        idle_inputs();
        @(negedge clk_i);
        drive_pt();
        @(negedge clk_i);
        drive_pt();
    endtask

    task automatic test_locked();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        bus.m1_cyc_i = 1;
        @(negedge clk_i);
        drive_pt();
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
        for (int i = 0; i < 3; i++) begin
            a = 32'h200 + ADDR_W'(4 * i);
            d = DATA_W'(8'h11 * (i + 1));
            bus.m1_stb_i = 1; bus.m1_we_i = 1; bus.m1_addr_i = a; bus.m1_dat_i = d;
            bus.m1_sel_i = 4'hF; bus.wbs_ack_i = 1;
            @(negedge clk_i);
            tests++;
            if ({bus.wbs_addr_o, bus.wbs_dat_o, bus.wbs_we_o, gnt_o, bus.m1_ack_o, bus.m0_ack_o} !==
                {a, d, 1'b1, 2'b10, 1'b1, 1'b0}) begin
                fails++; $display("FAIL locked_beat%0d: addr=%h dat=%h we=%b gnt=%b m1ack=%b m0ack=%b expected %h %h 1 10 1 0",
                                  i, bus.wbs_addr_o, bus.wbs_dat_o, bus.wbs_we_o, gnt_o,
                                  bus.m1_ack_o, bus.m0_ack_o, a, d);
            end
            drive_pt();
            bus.m1_stb_i = 0; bus.wbs_ack_i = 0;
            @(negedge clk_i);
            tests++;
            if (gnt_o !== 2'b10) begin
                fails++; $display("FAIL locked_hold%0d: gnt got %b expected 10", i, gnt_o);
            end
            drive_pt();
        end
        bus.m1_cyc_i = 0; bus.m1_we_i = 0;
        begin
            logic [1:0] exp_g [3] = '{2'b10, 2'b00, 2'b01};
            for (int c = 0; c < 3; c++) begin
                @(negedge clk_i);
                tests++;
                if (gnt_o !== exp_g[c]) begin
                    fails++; $display("FAIL locked_handover%0d: gnt got %b expected %b", c, gnt_o, exp_g[c]);
                end
                drive_pt();
            end
        end
        idle_inputs();
        @(negedge clk_i);
        drive_pt();
        @(negedge clk_i);
        drive_pt();
    endtask

    task automatic test_timeout();
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_addr_i = 32'h0000_0400;
        @(negedge clk_i);
        drive_pt();
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_addr_i = 32'h0000_0800;
        for (int k = 1; k <= int'(TIMEOUT); k++) begin
            @(negedge clk_i);
            tests++;
            if ({bus.m0_err_o, bus.wbs_cyc_o, bus.wbs_stb_o, bus.m1_err_o} !==
                {k == int'(TIMEOUT), k != int'(TIMEOUT), k != int'(TIMEOUT), 1'b0}) begin
                fails++; $display("FAIL timeout_stb%0d: m0err=%b cyc=%b stb=%b m1err=%b expected %b %b %b 0",
                                  k, bus.m0_err_o, bus.wbs_cyc_o, bus.wbs_stb_o, bus.m1_err_o,
                                  k == int'(TIMEOUT), k != int'(TIMEOUT), k != int'(TIMEOUT));
            end
            drive_pt();
        end
        @(negedge clk_i);
        tests++;
        if ({gnt_o, bus.m0_err_o} !== 3'b000) begin
            fails++; $display("FAIL timeout_idle: gnt=%b m0err=%b expected 00 0", gnt_o, bus.m0_err_o);
        end
        drive_pt();
        @(negedge clk_i);
        tests++;
        if ({gnt_o, bus.wbs_addr_o} !== {2'b10, 32'h0000_0800}) begin
            fails++; $display("FAIL timeout_next: gnt=%b addr=%h expected 10 00000800", gnt_o, bus.wbs_addr_o);
        end
        drive_pt();
        idle_inputs();
        @(negedge clk_i);
        drive_pt();
        @(negedge clk_i);
        drive_pt();
    endtask

    task automatic test_slave_err();
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = 1; bus.m1_addr_i = 32'h0000_0300;
        @(negedge clk_i);
        drive_pt();
        // two silent cycles, error, then TIMEOUT-1 silent cycles that must not expire
        for (int k = 0; k < 3 + int'(TIMEOUT) - 1; k++) begin
            bus.wbs_err_i = (k == 2);
            @(negedge clk_i);
            tests++;
            if ({bus.m1_err_o, bus.m0_err_o, bus.m1_ack_o, gnt_o} !== {k == 2, 1'b0, 1'b0, 2'b10}) begin
                fails++; $display("FAIL slverr_c%0d: m1err=%b m0err=%b m1ack=%b gnt=%b expected %b 0 0 10",
                                  k, bus.m1_err_o, bus.m0_err_o, bus.m1_ack_o, gnt_o, k == 2);
            end
            drive_pt();
        end
        bus.wbs_err_i = 0; bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
        @(negedge clk_i);
        drive_pt();
        @(negedge clk_i);
        tests++;
        if (gnt_o !== 2'b00) begin
            fails++; $display("FAIL slverr_release: gnt got %b expected 00", gnt_o);
        end
        drive_pt();
        idle_inputs();
    endtask

    // Random traffic against an ownership model: who holds the bus, who went last,
    // and how many consecutive strobed cycles have gone unanswered.
    task automatic test_random();
        int                owner;
        int                last;
        int                waiting;
        logic              c [2];
        logic              s [2];
        logic              w [2];
        logic [ADDR_W-1:0] ad [2];
        logic [DATA_W-1:0] dt [2];
        logic [SEL_W-1:0]  sl [2];
        logic              ack, err, expire;
        logic [DATA_W-1:0] rdat;
        logic [OUT_W-1:0]  exp_v;
        logic [DATA_W-1:0] rd [2];
        logic              ak [2], er [2];
        idle_inputs();
        rst_i = 0;
        drive_pt();
        rst_i = 1;
        owner = -1; last = 0; waiting = 0;
        c[0] = 0; c[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            drive_pt();
            for (int m = 0; m < 2; m++) begin
                if (!c[m]) c[m] = ($urandom % 4) == 0;
                else if (($urandom % 8) == 0) c[m] = 0;
                s[m]  = c[m] && (($urandom % 4) != 0);
                w[m]  = 1'($urandom);
                ad[m] = $urandom;
                dt[m] = $urandom;
                sl[m] = SEL_W'($urandom);
            end
            begin
                int r = $urandom % 16;
                ack = r < 6;
                err = (r == 6) || (r == 7);
            end
            rdat = $urandom;
            bus.m0_cyc_i = c[0]; bus.m0_stb_i = s[0]; bus.m0_we_i = w[0];
            bus.m0_addr_i = ad[0]; bus.m0_dat_i = dt[0]; bus.m0_sel_i = sl[0];
            bus.m1_cyc_i = c[1]; bus.m1_stb_i = s[1]; bus.m1_we_i = w[1];
            bus.m1_addr_i = ad[1]; bus.m1_dat_i = dt[1]; bus.m1_sel_i = sl[1];
            bus.wbs_ack_i = ack; bus.wbs_err_i = err; bus.wbs_dat_i = rdat;
            @(negedge clk_i);
            rd[0] = '0; rd[1] = '0; ak[0] = 0; ak[1] = 0; er[0] = 0; er[1] = 0;
            if (owner < 0) begin
                exp_v = '0;
                expire = 0;
            end else begin
                // expiry on the TIMEOUT-th unanswered strobed cycle in a row
                expire = s[owner] && !ack && !err && (waiting + 1 == int'(TIMEOUT));
                rd[owner] = rdat;
                ak[owner] = ack;
                er[owner] = err || expire;
                exp_v = {c[owner] && !expire, s[owner] && !expire, w[owner], ad[owner], dt[owner],
                         sl[owner], ak[0], er[0], rd[0], ak[1], er[1], rd[1],
                         owner == 1, owner == 0};
            end
            tests++;
            if (all_outs() !== exp_v) begin
                fails++; $display("FAIL random_c%0d: outputs got %h expected %h", i, all_outs(), exp_v);
            end
            if (owner < 0) begin
                if (c[0] && c[1]) owner = 1 - last;
                else if (c[0]) owner = 0;
                else if (c[1]) owner = 1;
                waiting = 0;
            end else if (!c[owner] || expire) begin
                last = owner;
                owner = -1;
                waiting = 0;
            end else if (s[owner] && !ack && !err) begin
                waiting++;
            end else begin
                waiting = 0;
            end
        end
        drive_pt();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_locked();
        test_timeout();
        test_slave_err();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_time_limit: run exceeded 2 ms, expected completion well before");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter. It shares the single external memory bus between the instruction-fetch unit (master 0) and the MEM-stage Wishbone unit (master 1).
- Grants ownership for a whole bus cycle (cyc held high) and routes the slave's ack, err and read data back to the owner only.
- Arbitration is round-robin on contention.
- A watchdog converts a hung slave into a bus error, so the pipeline's trap path can recover.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; select width is DATA_W/8.
- TIMEOUT, 255, cycles with stb high and no ack/err before a forced error; legal range 2..65535.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  fetch master strobes.
- m0_addr_i  in  ADDR_W  fetch address.
- m0_dat_i  in  DATA_W  fetch write data.
- m0_sel_i  in  DATA_W/8  fetch byte select.
- m0_dat_o  out  DATA_W  read data to fetch.
- m0_ack_o, m0_err_o  out  1 each  fetch ack / error.
- m1_cyc_i, m1_stb_i, m1_we_i, m1_addr_i, m1_dat_i, m1_sel_i  in  as for m0  LSU master.
- m1_dat_o, m1_ack_o, m1_err_o  out  as for m0  LSU responses.
- wbs_cyc_o, wbs_stb_o, wbs_we_o  out  1 each  slave strobes.
- wbs_addr_o  out  ADDR_W  slave address.
- wbs_dat_o  out  DATA_W  slave write data.
- wbs_sel_o  out  DATA_W/8  slave byte select.
- wbs_dat_i  in  DATA_W  slave read data.
- wbs_ack_i, wbs_err_i  in  1 each  slave ack / error.
- gnt_o  out  2  one-hot grant (bit0 = m0, bit1 = m1), for debug/perf counters.

Behaviour:

State machine:
- States: IDLE, OWN0, OWN1.
- Registers: state, last_gnt (1 bit), wd_cnt (clog2(TIMEOUT+1) bits).

Reset (rst_i = 0, immediate, asynchronous):
- state = IDLE, last_gnt = 0 (m0), wd_cnt = 0.
- All outputs read 0 while in reset and while IDLE.

IDLE transitions:
- Only m0_cyc_i high → OWN0.
- Only m1_cyc_i high → OWN1.
- Both high → grant the master that is not last_gnt. After reset this means m1 (LSU) wins the first tie.
- The grant takes effect on the next edge: one cycle of arbitration latency. No slave signal is asserted in IDLE.

OWNx (owner x):
- wbs_cyc_o/stb_o/we_o/addr_o/dat_o/sel_o = mx_* combinationally.
- mx_ack_o = wbs_ack_i, mx_err_o = wbs_err_i, mx_dat_o = wbs_dat_i.
- The non-owner sees ack = err = 0 and dat = 0. A requesting non-owner simply waits; the arbiter never drops its request.
- The grant is held for as long as mx_cyc_i = 1. This covers multiple stb/ack beats and read-modify sequences. The grant is not released on ack.
- mx_cyc_i = 0 → next state IDLE and last_gnt = x.
- No re-grant happens in the same cycle. There is a mandatory one-cycle idle gap between owners and between back-to-back cycles of one master.

Watchdog:
- In OWNx with wbs_stb_o = 1 and ack = err = 0, wd_cnt increments. It clears on any ack/err, on stb low, or on leaving OWNx.
- When wd_cnt == TIMEOUT-1 and still no ack/err:
  - that cycle: mx_err_o = 1 for exactly one cycle; wbs_cyc_o = wbs_stb_o = 0 forced.
  - next state IDLE, last_gnt = x, wd_cnt = 0.
- A slave ack/err arriving in that same cycle wins: it is passed through normally and no forced error occurs.
- After a timeout, if the master still holds cyc, it re-arbitrates from IDLE like a new request.

Simultaneous events:
- Owner drops cyc while the other master requests → IDLE for one cycle, then the other master is granted. last_gnt already points to the finished owner.
- Both drop → IDLE.
- wbs_ack_i/err_i while IDLE are ignored; nothing is routed.

Reset mid-transfer:
- The bus is released immediately (cyc/stb low asynchronously).
- No ack/err is delivered to either master.

Invariants:
- gnt_o is one-hot or zero.
- wbs_cyc_o = 1 only in OWNx.
- ack_o and err_o are never both asserted to the same master (slave protocol assumed).

Test Plan:
1. Reset: drive rst_i = 0 mid-OWN1 with stb high → wbs_cyc_o = 0 and gnt_o = 00 in the same cycle; after release with no requests, all outputs stay 0.
2. Single read: m0 cyc/stb at addr 0x0000_0100; slave acks two cycles later with 0xDEAD_BEEF → wbs_cyc_o rises one cycle after request, m0_dat_o = 0xDEAD_BEEF with m0_ack_o = 1, m1_ack_o = 0.
3. Contention: both cyc high from cycle 0 after reset → m1 granted first. After m1 drops cyc there is one idle cycle, then m0 is granted. Repeat the tie → m1 granted again (alternation).
4. Locked cycle: m1 holds cyc for three stb/ack beats (write 0x11, 0x22, 0x33 to 0x200, 0x204, 0x208) while m0 requests → m0 is not granted until m1 drops cyc; wbs_addr_o shows all three addresses in order.
5. Timeout: TIMEOUT = 4, m0 stb, slave silent → m0_err_o pulses exactly in the 4th cycle of stb; wbs_cyc_o is 0 that cycle; the next state is IDLE, and m1 is granted next if it is pending.
6. Slave error: wbs_err_i asserted on an m1 write → m1_err_o = 1 for one cycle, m0_err_o = 0, wd_cnt clears, and the grant holds until m1 drops cyc.
